// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, skid-buffer occupancy encoding and operand-pair type
package regfile_pkg;
  localparam int REG_W  = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;
  typedef struct packed {
    logic [REG_W-1:0] opA;
    logic [REG_W-1:0] opB;
  } pair_t;
endpackage

// File: rtl/operand_select.sv
// operand_select: NREG:1 register read mux with same-cycle write bypass
module operand_select
  import regfile_pkg::*;
#(
  parameter int W  = REG_W,
  parameter int N  = NREG,
  parameter int AW = ADDR_W
) (
  input  logic [N-1:0][W-1:0] i_regs,
  input  logic [N-1:0]        i_wen,
  input  logic [W-1:0]        i_wdata,
  input  logic [AW-1:0]       i_src,
  output logic [W-1:0]        o_val
);
  assign o_val = i_wen[i_src] ? i_wdata : i_regs[i_src];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads two source operands (B optionally immediate) into a 2-entry skid buffer toward the ALU
module operand_fetch
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  r0,
  input  logic [REG_W-1:0]  r1,
  input  logic [REG_W-1:0]  r2,
  input  logic [REG_W-1:0]  r3,
  input  logic [REG_W-1:0]  r4,
  input  logic [REG_W-1:0]  r5,
  input  logic [REG_W-1:0]  r6,
  input  logic [REG_W-1:0]  r7,
  input  logic [REG_W-1:0]  r8,
  input  logic [REG_W-1:0]  r9,
  input  logic [REG_W-1:0]  r10,
  input  logic [REG_W-1:0]  r11,
  input  logic [REG_W-1:0]  r12,
  input  logic [REG_W-1:0]  r13,
  input  logic [REG_W-1:0]  r14,
  input  logic [REG_W-1:0]  r15,
  input  logic [REG_W-1:0]  ALUBus,
  input  logic [NREG-1:0]   regEnable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic              useImm,
  input  logic [REG_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  opA,
  output logic [REG_W-1:0]  opB
);
  logic [NREG-1:0][REG_W-1:0] w_regs;
  logic [REG_W-1:0] w_sel_a, w_sel_b;
  pair_t w_new;
  logic  w_push, w_pop;
  occ_t  r_occ;
  pair_t r_head, r_tail;
  assign w_regs = {r15, r14, r13, r12, r11, r10, r9, r8, r7, r6, r5, r4, r3, r2, r1, r0};
  operand_select u_sel_a (
    .i_regs (w_regs),
    .i_wen  (regEnable),
    .i_wdata(ALUBus),
    .i_src  (srcA),
    .o_val  (w_sel_a)
  );
  operand_select u_sel_b (
    .i_regs (w_regs),
    .i_wen  (regEnable),
    .i_wdata(ALUBus),
    .i_src  (srcB),
    .o_val  (w_sel_b)
  );
  assign w_new     = '{opA: w_sel_a, opB: useImm ? imm : w_sel_b};
  assign req_ready = (r_occ != TWO);
  assign out_valid = (r_occ != EMPTY);
  assign w_push    = req_valid & req_ready;
  assign w_pop     = out_valid & out_ready;
  assign opA       = r_head.opA;
  assign opB       = r_head.opB;
  // Head always drives the outputs, so an emptied buffer keeps showing its last pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ  <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_occ)
        EMPTY: if (w_push) begin
          r_head <= w_new;
          r_occ  <= ONE;
        end
        ONE: if (w_push && w_pop) r_head <= w_new;
        else if (w_push) begin
          r_tail <= w_new;
          r_occ  <= TWO;
        end else if (w_pop) r_occ <= EMPTY;
        TWO: if (w_pop) begin
          r_head <= r_tail;
          r_occ  <= ONE;
        end
        default: r_occ <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand select, bypass, immediate, skid buffering and async reset
module tb_operand_fetch;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] r [NREG];
  logic [REG_W-1:0] ALUBus, imm, opA, opB;
  logic [NREG-1:0] regEnable;
  logic req_valid, req_ready, useImm, out_valid, out_ready;
  logic [ADDR_W-1:0] srcA, srcB;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]), .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]), .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
    .ALUBus(ALUBus), .regEnable(regEnable),
    .req_valid(req_valid), .req_ready(req_ready),
    .srcA(srcA), .srcB(srcB), .useImm(useImm), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .opA(opA), .opB(opB)
  );

  task automatic chk(input string tag, input logic [REG_W-1:0] obs, input logic [REG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < NREG; i++) r[i] = '0;
    r[3] = 16'h1234;
    r[7] = 16'h00FF;
    ALUBus = '0; imm = '0; regEnable = '0;
    req_valid = 1'b0; useImm = 1'b0; out_ready = 1'b0;
    srcA = '0; srcB = '0;
    #1;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_opA", opA, 16'h0000);
    chk("rst_opB", opB, 16'h0000);
    chk("rst_ready", {15'd0, req_ready}, 16'd1);
    step(); step();
    reset = 1'b1;
    req_valid = 1'b1; srcA = 4'd3; srcB = 4'd7; out_ready = 1'b1;
    step();
    chk("first_valid", {15'd0, out_valid}, 16'd1);
    chk("first_opA", opA, 16'h1234);
    chk("first_opB", opB, 16'h00FF);
    r[5] = 16'h0001; regEnable = 16'h0020; ALUBus = 16'hBEEF; srcA = 4'd5; srcB = 4'd5;
    step();
    chk("byp_valid", {15'd0, out_valid}, 16'd1);
    chk("byp_opA", opA, 16'hBEEF);
    chk("byp_opB", opB, 16'hBEEF);
    r[2] = 16'h2222; regEnable = 16'h0004; ALUBus = 16'hDEAD;
    srcA = 4'd3; srcB = 4'd2; useImm = 1'b1; imm = 16'h8000;
    step();
    chk("imm_opA", opA, 16'h1234);
    chk("imm_opB", opB, 16'h8000);
    req_valid = 1'b0; useImm = 1'b0; regEnable = '0;
    step();
    chk("drain_valid", {15'd0, out_valid}, 16'd0);
    chk("hold_opA", opA, 16'h1234);
    chk("hold_opB", opB, 16'h8000);
    r[1] = 16'h1111; r[4] = 16'h4444; r[6] = 16'h6666; r[8] = 16'h8888; r[9] = 16'h9999;
    out_ready = 1'b0; req_valid = 1'b1; srcA = 4'd1; srcB = 4'd2;
    step();
    chk("bp1_ready", {15'd0, req_ready}, 16'd1);
    chk("bp1_opA", opA, 16'h1111);
    chk("bp1_opB", opB, 16'h2222);
    srcA = 4'd4; srcB = 4'd6;
    step();
    chk("bp2_ready", {15'd0, req_ready}, 16'd0);
    chk("bp2_opA", opA, 16'h1111);
    srcA = 4'd8; srcB = 4'd9;
    step();
    chk("bp3_ready", {15'd0, req_ready}, 16'd0);
    chk("bp3_valid", {15'd0, out_valid}, 16'd1);
    chk("bp3_opA", opA, 16'h1111);
    chk("bp3_opB", opB, 16'h2222);
    out_ready = 1'b1;
    step();
    chk("dr1_opA", opA, 16'h4444);
    chk("dr1_opB", opB, 16'h6666);
    chk("dr1_ready", {15'd0, req_ready}, 16'd1);
    step();
    chk("dr2_opA", opA, 16'h8888);
    chk("dr2_opB", opB, 16'h9999);
    chk("dr2_valid", {15'd0, out_valid}, 16'd1);
    req_valid = 1'b0;
    step();
    chk("dr3_valid", {15'd0, out_valid}, 16'd0);
    for (int i = 0; i < NREG; i++) r[i] = 16'hC000 | 16'(i);
    req_valid = 1'b1; out_ready = 1'b1; srcB = 4'd15;
    for (int k = 0; k < 10; k++) begin
      srcA = 4'(k);
      step();
      chk($sformatf("st%0d_valid", k), {15'd0, out_valid}, 16'd1);
      chk($sformatf("st%0d_opA", k), opA, 16'hC000 | 16'(k));
      chk($sformatf("st%0d_opB", k), opB, 16'hC00F);
      chk($sformatf("st%0d_ready", k), {15'd0, req_ready}, 16'd1);
    end
    req_valid = 1'b0;
    step();
    chk("st_end_valid", {15'd0, out_valid}, 16'd0);
    out_ready = 1'b0; req_valid = 1'b1; srcA = 4'd1; srcB = 4'd2;
    step(); step();
    chk("full_ready", {15'd0, req_ready}, 16'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {15'd0, out_valid}, 16'd0);
    chk("arst_opA", opA, 16'h0000);
    chk("arst_opB", opB, 16'h0000);
    chk("arst_ready", {15'd0, req_ready}, 16'd1);
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post1_valid", {15'd0, out_valid}, 16'd0);
    step();
    chk("post2_valid", {15'd0, out_valid}, 16'd0);
    chk("post2_opA", opA, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Read-side companion to the 16×16-bit register file. Accepts a request naming two source registers (A and B, with optional immediate substitution on B) and reads them from the register outputs r0–r15. Same-cycle writes on ALUBus/regEnable are bypassed into the read. The operand pair is delivered to the ALU through a valid/ready interface backed by a 2-entry skid buffer. It sits between the instruction decoder and the ALU, at the opposite end of the register file from the write path.

## Interface
Parameters:
- REG_W, 16, register and operand width
- NREG, 16, number of architectural registers
- ADDR_W, 4, register address width (log2 NREG)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- r0 … r15  input  REG_W each  current register file contents
- ALUBus  input  REG_W  value being written into the register file this cycle
- regEnable  input  NREG  per-register write enables for this cycle; may be multi-hot
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready at a rising edge
- srcA  input  ADDR_W  register index for operand A
- srcB  input  ADDR_W  register index for operand B
- useImm  input  1  operand B is taken from imm instead of a register
- imm  input  REG_W  immediate value
- out_valid  output  1  opA/opB hold a valid pair
- out_ready  input  1  ALU consumes the pair when out_valid & out_ready at a rising edge
- opA  output  REG_W  operand A
- opB  output  REG_W  operand B

## Operation
- Operand select, per operand:
  - If regEnable[src] = 1, the value is ALUBus (bypass).
  - Otherwise the value is r[src].
  - For B only, useImm = 1 overrides both and selects imm. Bypass and register read are then ignored.
- Values are sampled on the accepting edge. Buffered entries are snapshots and are not updated by later writes.
- Skid buffer with occupancy states EMPTY, ONE, TWO. The head entry drives opA/opB. When the buffer is empty, opA and opB hold their last head value.
- req_ready = (occupancy != TWO). It is derived combinationally from registered occupancy only, never from out_ready.
- Occupancy transitions (push = req_valid & req_ready; pop = out_valid & out_ready):
  - EMPTY: push → ONE.
  - ONE: push only → TWO. Pop only → EMPTY. Push and pop together → ONE, and the new entry becomes head.
  - TWO: pop → ONE, and the second entry moves to head. Push is impossible because req_ready = 0.
- out_valid = (occupancy != EMPTY).
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Latency: a request accepted at edge N appears on opA/opB with out_valid = 1 after edge N (cycle N+1).
- Throughput: one pair per cycle while out_ready is held high.
- Reset (reset = 0, asynchronous): occupancy = EMPTY, out_valid = 0, opA = 0, opB = 0, both buffer entries = 0.
- req_ready reads 1 during reset, but no push occurs while reset is low.
- Reset mid-operation discards all buffered entries immediately. No pop is reported.
- The first push is possible on the first rising edge after reset deasserts.
- Simultaneous write and read of the same register: the bypassed ALUBus value is captured, not the stale r[src].
- srcA = srcB is legal; both operands receive the identical value.
- out_valid must not drop without a pop, and opA/opB must stay stable while out_valid = 1 and out_ready = 0.

## Structure
- Shared package regfile_pkg holds:
  - REG_W, NREG, ADDR_W constants.
  - The occupancy encoding (EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2).
  - The operand-pair struct {opA, opB}.
- One sub-module, operand_select: combinational NREG:1 mux with regEnable bypass, instantiated twice (A and B). The immediate override sits outside it, on the B path.
- The top level holds the two-entry storage and the occupancy register.

## Test plan
- Reset with r3 = 16'h1234, r7 = 16'h00FF. After release, request srcA = 3, srcB = 7 with out_ready = 1 → next cycle out_valid = 1, opA = 16'h1234, opB = 16'h00FF.
- Bypass: r5 = 16'h0001. Same cycle: regEnable = 16'h0020, ALUBus = 16'hBEEF, request srcA = srcB = 5 → opA = opB = 16'hBEEF.
- Immediate: srcB = 2, useImm = 1, imm = 16'h8000, regEnable[2] = 1 → opB = 16'h8000, and the bypass is ignored.
- Backpressure: out_ready = 0, push three requests with distinct values:
  - req_ready drops to 0 after the second push.
  - The first pair is held stable.
  - Raising out_ready drains the pairs in order; the third request is then accepted.
- Streaming: out_ready = 1 and req_valid = 1 for 10 cycles with incrementing srcA → 10 pairs in order, one per cycle, and occupancy never reaches TWO.
- Asynchronous reset asserted mid-cycle with occupancy = TWO → out_valid = 0 and opA = opB = 0 immediately. After release, no stale pair is emitted.
